// File: rtl/cube_pkg.sv
// Shared constants for the cube state engine: geometry, ring tables,
// LFSR taps and the FSM state type.
package cube_pkg;

    localparam int COLOUR_W = 3;
    localparam int FACES    = 6;
    localparam int FACELETS = 54;
    localparam int STATE_W  = FACELETS * COLOUR_W;
    localparam int RING_LEN = 12;

    localparam logic [2:0] FACE_U = 3'd0;
    localparam logic [2:0] FACE_R = 3'd1;
    localparam logic [2:0] FACE_F = 3'd2;
    localparam logic [2:0] FACE_D = 3'd3;
    localparam logic [2:0] FACE_L = 3'd4;
    localparam logic [2:0] FACE_B = 3'd5;

    // Feedback taps for x^16+x^14+x^13+x^11+1 (bits 15, 13, 12, 10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SHUF
    } engine_state_t;

    // Destination offset within a face for each source offset under a CW turn
    localparam int OWN_DST [9] = '{2, 5, 8, 1, 4, 7, 0, 3, 6};

    // Facelets bordering each face, listed clockwise as seen from outside
    // that face; a CW turn moves the colour at entry k to entry k+3.
    localparam int RING [FACES][RING_LEN] = '{
        '{47, 46, 45, 11, 10,  9, 20, 19, 18, 38, 37, 36},
        '{ 8,  5,  2, 45, 48, 51, 35, 32, 29, 26, 23, 20},
        '{ 6,  7,  8,  9, 12, 15, 29, 28, 27, 44, 41, 38},
        '{24, 25, 26, 15, 16, 17, 51, 52, 53, 42, 43, 44},
        '{ 0,  3,  6, 18, 21, 24, 27, 30, 33, 53, 50, 47},
        '{ 2,  1,  0, 36, 39, 42, 33, 34, 35, 17, 14, 11}
    };

    // Solved cube: every facelet carries the colour of its own face
    function automatic logic [STATE_W-1:0] solved_state();
        logic [STATE_W-1:0] s;
        s = '0;
        for (int i = 0; i < FACELETS; i++) begin
            s[i*COLOUR_W +: COLOUR_W] = COLOUR_W'(i / 9);
        end
        return s;
    endfunction

endpackage

// File: rtl/cube_turn.sv
// Combinational clockwise quarter turn of one face over the full cube state.
module cube_turn
    import cube_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [2:0]         face,
    output logic [STATE_W-1:0] rotated
);

    // Rotate the chosen face in place and shift its border ring by three
    always_comb begin
        rotated = state;
        for (int f = 0; f < FACES; f++) begin
            if (face == 3'(f)) begin
                for (int k = 0; k < 9; k++) begin
                    rotated[(f*9 + OWN_DST[k])*COLOUR_W +: COLOUR_W] =
                        state[(f*9 + k)*COLOUR_W +: COLOUR_W];
                end
                for (int k = 0; k < RING_LEN; k++) begin
                    rotated[RING[f][(k+3) % RING_LEN]*COLOUR_W +: COLOUR_W] =
                        state[RING[f][k]*COLOUR_W +: COLOUR_W];
                end
            end
        end
    end

endmodule

// File: rtl/cube_state_engine.sv
// Cube state holder: accepts single moves and LFSR-driven shuffles, and
// commits turns only during vertical blanking so the renderer never sees
// a partially applied move.
module cube_state_engine
    import cube_pkg::*;
#(
    parameter int unsigned SHUFFLE_MOVES = 20,
    parameter logic [11:0] LFSR_FILL     = 12'hACE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                vblank,
    input  logic                move_valid,
    input  logic [2:0]          move_face,
    input  logic                move_dir,
    output logic                move_ready,
    input  logic                shuffle,
    input  logic [3:0]          random,
    input  logic                retain,
    output logic [STATE_W-1:0]  facelets,
    output logic                busy,
    output logic                solved,
    output logic [7:0]          move_count
);

    localparam logic [STATE_W-1:0] SOLVED       = solved_state();
    localparam logic [7:0]         SHUFFLE_LOAD = 8'(SHUFFLE_MOVES);

    engine_state_t      state;
    logic [STATE_W-1:0] cube;
    logic [STATE_W-1:0] turned;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_next;
    logic [7:0]         remaining;
    logic [1:0]         turns;
    logic [2:0]         face_q;
    logic [2:0]         turn_face;
    logic               shuffle_q;
    logic               shuffle_edge;
    logic               step_en;

    assign shuffle_edge = shuffle & ~shuffle_q;
    assign step_en      = vblank & ~retain;
    assign lfsr_next    = {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    assign turn_face    = (state == ST_SHUF) ? lfsr[2:0] : face_q;

    assign move_ready = (state == ST_IDLE) & ~retain;
    assign busy       = (state != ST_IDLE);
    assign solved     = (cube == SOLVED);
    assign facelets   = cube;

    cube_turn u_turn (
        .state   (cube),
        .face    (turn_face),
        .rotated (turned)
    );

    // Move/shuffle sequencer; every commit is one registered turn of the cube
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cube       <= SOLVED;
            lfsr       <= {4'h0, LFSR_FILL};
            remaining  <= 8'd0;
            turns      <= 2'd0;
            face_q     <= FACE_U;
            shuffle_q  <= 1'b0;
            move_count <= 8'd0;
        end else begin
            shuffle_q <= shuffle;
            case (state)
                ST_IDLE: begin
                    if (shuffle_edge && !retain) begin
                        lfsr      <= {random, LFSR_FILL};
                        remaining <= SHUFFLE_LOAD;
                        state     <= ST_SHUF;
                    end else if (move_valid && move_ready && (move_face < 3'd6)) begin
                        face_q <= move_face;
                        turns  <= move_dir ? 2'd3 : 2'd1;
                        state  <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (step_en) begin
                        cube       <= turned;
                        move_count <= move_count + 8'd1;
                        turns      <= turns - 2'd1;
                        if (turns == 2'd1) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_SHUF: begin
                    if (step_en) begin
                        lfsr <= lfsr_next;
                        if (lfsr[2:0] < 3'd6) begin
                            cube       <= turned;
                            move_count <= move_count + 8'd1;
                            remaining  <= remaining - 8'd1;
                            if (remaining == 8'd1) begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cube_state_engine.sv
// Directed bench for cube_state_engine with a geometric cube model.
module tb_cube_state_engine;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         vblank = 1'b0;
    logic         move_valid = 1'b0;
    logic [2:0]   move_face = 3'd0;
    logic         move_dir = 1'b0;
    logic         move_ready;
    logic         shuffle = 1'b0;
    logic [3:0]   random = 4'h0;
    logic         retain = 1'b0;
    logic [161:0] facelets;
    logic         busy;
    logic         solved;
    logic [7:0]   move_count;

    int checks = 0;
    int errors = 0;
    int perm [6][54];
    logic [161:0] solvedRef;
    logic [161:0] expected;
    logic [161:0] shufRef;
    logic [161:0] snapshot;
    logic [7:0]   frozen;
    int           busyCycles;

    cube_state_engine #(
        .SHUFFLE_MOVES (20),
        .LFSR_FILL     (12'hACE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vblank     (vblank),
        .move_valid (move_valid),
        .move_face  (move_face),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .shuffle    (shuffle),
        .random     (random),
        .retain     (retain),
        .facelets   (facelets),
        .busy       (busy),
        .solved     (solved),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    // Position of sticker i on a 3x3x3 grid plus its outward normal
    function automatic void locate(input int i, output int px, output int py, output int pz,
                                   output int nx, output int ny, output int nz);
        int f, r, c;
        f = i / 9;
        r = (i % 9) / 3;
        c = i % 3;
        px = 0; py = 0; pz = 0; nx = 0; ny = 0; nz = 0;
        case (f)
            0: begin px = c - 1; py = 1;     pz = r - 1; ny = 1;  end
            1: begin px = 1;     py = 1 - r; pz = 1 - c; nx = 1;  end
            2: begin px = c - 1; py = 1 - r; pz = 1;     nz = 1;  end
            3: begin px = c - 1; py = -1;    pz = 1 - r; ny = -1; end
            4: begin px = -1;    py = 1 - r; pz = c - 1; nx = -1; end
            default: begin px = 1 - c; py = 1 - r; pz = -1; nz = -1; end
        endcase
    endfunction

    // Where sticker i lands after a CW turn of face f (rotation by -90 deg about the face normal)
    function automatic int turnDest(input int f, input int i);
        int ax, ay, az, d0, d1, d2;
        int px, py, pz, nx, ny, nz;
        int qx, qy, qz, mx, my, mz, kp, kn;
        int jx, jy, jz, jnx, jny, jnz;
        locate(f*9 + 4, d0, d1, d2, ax, ay, az);
        locate(i, px, py, pz, nx, ny, nz);
        if (ax*px + ay*py + az*pz != 1) return i;
        kp = ax*px + ay*py + az*pz;
        kn = ax*nx + ay*ny + az*nz;
        qx = ax*kp - (ay*pz - az*py);
        qy = ay*kp - (az*px - ax*pz);
        qz = az*kp - (ax*py - ay*px);
        mx = ax*kn - (ay*nz - az*ny);
        my = ay*kn - (az*nx - ax*nz);
        mz = az*kn - (ax*ny - ay*nx);
        for (int j = 0; j < 54; j++) begin
            locate(j, jx, jy, jz, jnx, jny, jnz);
            if (jx == qx && jy == qy && jz == qz && jnx == mx && jny == my && jnz == mz) return j;
        end
        return i;
    endfunction

    function automatic logic [161:0] modelTurn(input logic [161:0] st, input int f);
        logic [161:0] res;
        res = st;
        for (int i = 0; i < 54; i++) begin
            res[perm[f][i]*3 +: 3] = st[i*3 +: 3];
        end
        return res;
    endfunction

    function automatic logic [161:0] shuffleModel(input logic [3:0] seed, input int moves);
        logic [15:0]  l;
        logic [161:0] st;
        int           rem;
        l   = {seed, 12'hACE};
        st  = solvedRef;
        rem = moves;
        for (int guard = 0; guard < 10000 && rem > 0; guard++) begin
            if (l[2:0] < 3'd6) begin
                st  = modelTurn(st, int'(l[2:0]));
                rem = rem - 1;
            end
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        return st;
    endfunction

    task automatic checkOutput(input string tag, input logic [161:0] actual, input logic [161:0] want);
        checks++;
        if (actual !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset      = 1'b0;
        move_valid = 1'b0;
        shuffle    = 1'b0;
        retain     = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic applyStimulus(input logic [2:0] face, input logic dir);
        bit taken;
        taken      = 1'b0;
        move_valid = 1'b1;
        move_face  = face;
        move_dir   = dir;
        for (int t = 0; t < 20 && !taken; t++) begin
            if (move_ready) taken = 1'b1;
            tick(1);
        end
        move_valid = 1'b0;
        if (!taken) checkOutput("move_handshake_timeout", 162'(0), 162'(1));
    endtask

    task automatic waitIdle(input int budget);
        int t;
        t = 0;
        while (busy && t < budget) begin
            tick(1);
            t++;
        end
        if (busy) checkOutput("idle_timeout", 162'(busy), 162'(0));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int f = 0; f < 6; f++)
            for (int i = 0; i < 54; i++)
                perm[f][i] = turnDest(f, i);
        for (int i = 0; i < 54; i++) solvedRef[i*3 +: 3] = 3'(i / 9);

        // Reset state
        vblank = 1'b1;
        doReset();
        checkOutput("reset_facelets", facelets, solvedRef);
        checkOutput("reset_solved", 162'(solved), 162'(1));
        checkOutput("reset_count", 162'(move_count), 162'(0));
        checkOutput("reset_ready", 162'(move_ready), 162'(1));
        checkOutput("reset_busy", 162'(busy), 162'(0));

        // Single U CW, then three more to return to solved
        applyStimulus(3'd0, 1'b0);
        waitIdle(10);
        expected = modelTurn(solvedRef, 0);
        checkOutput("u1_state", facelets, expected);
        checkOutput("u1_centre_u", 162'(facelets[2:0]), 162'(0));
        checkOutput("u1_f_top_row", 162'(facelets[62:54]), 162'(9'b001_001_001));
        checkOutput("u1_solved", 162'(solved), 162'(0));
        checkOutput("u1_count", 162'(move_count), 162'(1));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(3'd0, 1'b0);
            waitIdle(10);
        end
        checkOutput("u4_state", facelets, solvedRef);
        checkOutput("u4_solved", 162'(solved), 162'(1));
        checkOutput("u4_count", 162'(move_count), 162'(4));

        // R CCW takes three vblank commits, then R CW restores
        doReset();
        applyStimulus(3'd1, 1'b1);
        busyCycles = 0;
        while (busy && busyCycles < 20) begin
            busyCycles++;
            tick(1);
        end
        checkOutput("rccw_busy_cycles", 162'(busyCycles), 162'(3));
        expected = modelTurn(modelTurn(modelTurn(solvedRef, 1), 1), 1);
        checkOutput("rccw_state", facelets, expected);
        checkOutput("rccw_count", 162'(move_count), 162'(3));
        applyStimulus(3'd1, 1'b0);
        waitIdle(10);
        checkOutput("rccw_rcw_count", 162'(move_count), 162'(4));
        checkOutput("rccw_rcw_solved", 162'(solved), 162'(1));

        // No commit outside vblank
        doReset();
        vblank = 1'b0;
        applyStimulus(3'd2, 1'b0);
        checkOutput("novb_busy_start", 162'(busy), 162'(1));
        tick(100);
        checkOutput("novb_state_held", facelets, solvedRef);
        checkOutput("novb_busy_held", 162'(busy), 162'(1));
        checkOutput("novb_count_held", 162'(move_count), 162'(0));
        vblank = 1'b1;
        tick(1);
        checkOutput("vb_commit_count", 162'(move_count), 162'(1));
        checkOutput("vb_commit_idle", 162'(busy), 162'(0));
        checkOutput("vb_commit_state", facelets, modelTurn(solvedRef, 2));

        // Illegal face is accepted and dropped; retain blocks acceptance
        doReset();
        applyStimulus(3'd6, 1'b0);
        checkOutput("illegal_busy", 162'(busy), 162'(0));
        checkOutput("illegal_count", 162'(move_count), 162'(0));
        checkOutput("illegal_state", facelets, solvedRef);
        retain = 1'b1;
        #1;
        checkOutput("retain_ready", 162'(move_ready), 162'(0));
        retain = 1'b0;
        tick(1);

        // Shuffle seed 5 with a simultaneous move request: shuffle wins
        shufRef = shuffleModel(4'h5, 20);
        doReset();
        random     = 4'h5;
        move_valid = 1'b1;
        move_face  = 3'd0;
        move_dir   = 1'b0;
        shuffle    = 1'b1;
        tick(1);
        move_valid = 1'b0;
        shuffle    = 1'b0;
        checkOutput("shuf_busy", 162'(busy), 162'(1));
        checkOutput("shuf_move_not_taken", 162'(move_count), 162'(0));
        waitIdle(500);
        checkOutput("shuf_count", 162'(move_count), 162'(20));
        checkOutput("shuf_state", facelets, shufRef);

        // Same seed from reset gives the same cube
        doReset();
        random  = 4'h5;
        shuffle = 1'b1;
        tick(1);
        shuffle = 1'b0;
        waitIdle(500);
        checkOutput("shuf_repeat_state", facelets, shufRef);

        // Retain freezes a running shuffle without altering its outcome
        doReset();
        random  = 4'h5;
        shuffle = 1'b1;
        tick(1);
        shuffle = 1'b0;
        tick(5);
        retain   = 1'b1;
        frozen   = move_count;
        snapshot = facelets;
        tick(50);
        checkOutput("retain_count", 162'(move_count), 162'(frozen));
        checkOutput("retain_state", facelets, snapshot);
        checkOutput("retain_busy", 162'(busy), 162'(1));
        retain = 1'b0;
        waitIdle(500);
        checkOutput("retain_final_state", facelets, shufRef);
        checkOutput("retain_final_count", 162'(move_count), 162'(20));

        // Asynchronous reset mid-shuffle
        shuffle = 1'b1;
        tick(1);
        shuffle = 1'b0;
        tick(4);
        checkOutput("midshuf_busy", 162'(busy), 162'(1));
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_solved", 162'(solved), 162'(1));
        checkOutput("async_busy", 162'(busy), 162'(0));
        checkOutput("async_count", 162'(move_count), 162'(0));
        checkOutput("async_state", facelets, solvedRef);
        tick(1);
        reset = 1'b1;
        tick(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cube_state_engine.md
Name: cube_state_engine

Overview:
- Holds the 54-facelet Rubik's cube state and applies quarter-turn moves to it.
- Runs scripted shuffles from an internal LFSR.
- Sits directly upstream of the cube renderer: the renderer reads the flattened `facelets` bus every pixel.
- State commits only during vertical blanking, so a frame never shows a half-applied move.

Parameters:
- SHUFFLE_MOVES, 20: number of accepted quarter turns per shuffle (1..255).
- LFSR_FILL, 12'hACE: constant low 12 bits of the LFSR seed.

Ports:
- clk  in  1  system clock; all state is in this domain.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- vblank  in  1  high during vertical blanking; moves commit only while high.
- move_valid  in  1  single-move request.
- move_face  in  3  face to turn: 0=U 1=R 2=F 3=D 4=L 5=B; values 6,7 are illegal.
- move_dir  in  1  0 = clockwise, 1 = counter-clockwise.
- move_ready  out  1  engine can accept a move this cycle.
- shuffle  in  1  button level; its rising edge starts a shuffle.
- random  in  4  shuffle seed bits.
- retain  in  1  freeze: while high, no move commits and no request is accepted.
- facelets  out  162  54 x 3-bit colours. Facelet index = face*9 + row*3 + col; facelet i occupies bits [3i+2:3i].
- busy  out  1  high in any state other than IDLE.
- solved  out  1  every facelet equals its face index.
- move_count  out  8  committed quarter turns since reset; wraps 255→0.

Behaviour:
- Reset (async assert, sync release):
  - facelet i = i/9 (solved).
  - FSM = IDLE; move_count = 0; busy = 0; solved = 1; move_ready = 1; LFSR = {4'h0, LFSR_FILL}; shuffle edge register = 0.
- move_ready = (state == IDLE) & ~retain.
- Handshake:
  - A move is accepted on a cycle with move_valid & move_ready.
  - If move_face ≥ 6, the request is accepted and dropped: no state change, no count.
  - Face/dir are latched on acceptance; inputs may change afterwards.
- FSM states:
  - IDLE:
    - Shuffle rising edge has priority over a simultaneous move_valid; the move is not accepted.
    - On a shuffle edge: seed LFSR = {random, LFSR_FILL}, load remaining = SHUFFLE_MOVES, go SHUF.
    - Else on an accepted legal move: turns = 1 (CW) or 3 (CCW), go APPLY.
  - APPLY:
    - On each cycle with vblank & ~retain: apply one CW quarter turn to the latched face, move_count += 1, turns -= 1.
    - When turns reaches 0, go IDLE.
    - A CCW move therefore adds 3 to move_count.
  - SHUF:
    - On each cycle with vblank & ~retain:
      - If LFSR[2:0] ≥ 6: skip, apply nothing.
      - Else: apply a CW turn on face LFSR[2:0], move_count += 1, remaining -= 1.
      - Step the LFSR on every one of these cycles.
    - When remaining reaches 0, go IDLE.
- With vblank low or retain high, APPLY and SHUF stall with all state held. This includes the LFSR and counters.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifting left; new bit = b15^b13^b12^b10.
  - The seed is never zero because LFSR_FILL ≠ 0.
- CW quarter turn of face f:
  - The face's own 9 facelets rotate: corners 0→2→8→6→0, edges 1→5→7→3→1; centre 4 is fixed.
  - 12 adjacent-ring facelets cycle by 3 positions, using the fixed tables in the package.
  - A turn is one registered update of the whole 162-bit state.
- solved is combinational from the state register, so it is valid the cycle after any commit.
- shuffle edge detection: register the previous shuffle level. An edge arriving while not IDLE is ignored, and is not queued.
- Reset asserted mid-shuffle or mid-move aborts immediately to the solved state.

Decomposition:
- Package cube_pkg:
  - Face constants U..B and colour width 3.
  - FACES = 6, FACELETS = 54.
  - Per-face ring tables: 6 × 12 facelet indices, CW order.
  - LFSR tap constant.
- Sub-module cube_turn: purely combinational.
  - Inputs: 162-bit state, 3-bit face.
  - Output: the CW-rotated state.
  - Instantiated once; the FSM registers its output.
- The LFSR stays inline.

Test Plan:
- Reset then release, vblank=1 → facelets equals solved pattern (facelet i = i/9), solved=1, move_count=0, move_ready=1.
- Move U CW with vblank=1 → facelet 0 (U) unchanged colour; F-row facelets 18..20 become R colour 1; solved=0; move_count=1. Four U CW moves → solved=1, move_count=4.
- Move R CCW, then move R CW → move_count=4, solved=1. During the CCW move, busy is high for exactly 3 vblank cycles.
- Hold vblank=0, issue move F CW → busy=1, no facelet change for 100 cycles. Raise vblank → one commit, then IDLE.
- random=4'h5, shuffle pulse, SHUFFLE_MOVES=20, vblank=1 → busy until move_count=20, final state matches a reference model using seed 16'h5ACE. Repeating with the same seed from reset gives an identical state.
- During the shuffle, retain=1 for 50 cycles → move_count frozen. Then assert reset mid-shuffle → solved=1, busy=0, move_count=0 asynchronously.
